// File: rtl/full_adder_pkg.sv
// Shared definitions for the full adder lab: checker states and stimulus vector layout.
package full_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned VEC_W   = 3;
  localparam int unsigned A_BIT   = 2;
  localparam int unsigned B_BIT   = 1;
  localparam int unsigned CIN_BIT = 0;

endpackage

// File: rtl/full_adder_ref.sv
// Combinational golden model of a 1-bit full adder, driven by a packed {a, b, c_in} vector.
module full_adder_ref
  import full_adder_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             s,
  output logic             c
);

  assign {c, s} = {1'b0, vec[A_BIT]} + {1'b0, vec[B_BIT]} + {1'b0, vec[CIN_BIT]};

endmodule

// File: rtl/full_adder_checker.sv
// Response checker for an exhaustive full adder sweep: checks result and arrival order,
// counts errors (saturating) and captures the first failing vector.
module full_adder_checker
  import full_adder_pkg::*;
#(
  parameter int unsigned N_VECTORS = 8,
  parameter int unsigned ERR_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [VEC_W-1:0] in_vec,
  input  logic             in_s,
  input  logic             in_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_seen,
  output logic [VEC_W-1:0] fail_vec
);

  localparam int unsigned IDX_W = $clog2(N_VECTORS + 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             exp_s, exp_c;
  logic             accept, restart, last, vec_err;

  full_adder_ref u_ref (
    .vec (in_vec),
    .s   (exp_s),
    .c   (exp_c)
  );

  assign accept  = (state == RUN) && in_valid;
  assign restart = (state != RUN) && start;
  assign last    = (idx == IDX_W'(N_VECTORS - 1));
  // Order check compares against the index modulo 8, so sweeps longer than 8 wrap.
  assign vec_err = ({in_c, in_s} != {exp_c, exp_s}) || (in_vec != VEC_W'(idx));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (accept && last) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      err_count <= '0;
      fail_seen <= 1'b0;
      fail_vec  <= '0;
    end else begin
      state <= state_nxt;
      if (restart) begin
        idx       <= '0;
        err_count <= '0;
        fail_seen <= 1'b0;
        fail_vec  <= '0;
      end else if (accept) begin
        idx <= idx + 1'b1;
        if (vec_err) begin
          if (err_count != '1) err_count <= err_count + 1'b1;
          if (!fail_seen) begin
            fail_seen <= 1'b1;
            fail_vec  <= in_vec;
          end
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_full_adder_checker.sv
// Directed bench for full_adder_checker: three instances (8/4, 8/2, 16/4) share one stimulus stream.
module tb_full_adder_checker;

  logic       clk, rst, start, in_valid, in_s, in_c;
  logic [2:0] in_vec;

  logic       busy, done, pass, fail_seen;
  logic [3:0] err_count;
  logic [2:0] fail_vec;

  logic       s2_busy, s2_done, s2_pass, s2_fail_seen;
  logic [1:0] s2_err_count;
  logic [2:0] s2_fail_vec;

  logic       n16_busy, n16_done, n16_pass, n16_fail_seen;
  logic [3:0] n16_err_count;
  logic [2:0] n16_fail_vec;

  int checks = 0;
  int failures = 0;

  // Hand-derived truth table, bit i = output for vector i.
  logic [7:0] s_tab = 8'b1001_0110;
  logic [7:0] c_tab = 8'b1110_1000;

  full_adder_checker #(.N_VECTORS(8), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_vec(in_vec),
    .in_s(in_s), .in_c(in_c), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_seen(fail_seen), .fail_vec(fail_vec)
  );

  full_adder_checker #(.N_VECTORS(8), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_vec(in_vec),
    .in_s(in_s), .in_c(in_c), .busy(s2_busy), .done(s2_done), .pass(s2_pass),
    .err_count(s2_err_count), .fail_seen(s2_fail_seen), .fail_vec(s2_fail_vec)
  );

  full_adder_checker #(.N_VECTORS(16), .ERR_W(4)) dut_n16 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_vec(in_vec),
    .in_s(in_s), .in_c(in_c), .busy(n16_busy), .done(n16_done), .pass(n16_pass),
    .err_count(n16_err_count), .fail_seen(n16_fail_seen), .fail_vec(n16_fail_vec)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present inputs for exactly one rising edge; returns at the following falling edge.
  task automatic apply(input logic st, input logic v, input logic [2:0] vec,
                       input logic s, input logic c);
    start = st; in_valid = v; in_vec = vec; in_s = s; in_c = c;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%0b exp=0", pass); end
    checks++; if (err_count !== 4'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err_count); end
    checks++; if (fail_seen !== 1'b0) begin failures++; $display("FAIL reset_fail_seen got=%0b exp=0", fail_seen); end
    checks++; if (fail_vec !== 3'd0) begin failures++; $display("FAIL reset_fail_vec got=%0d exp=0", fail_vec); end
    checks++; if (s2_busy !== 1'b0 || n16_busy !== 1'b0) begin failures++; $display("FAIL reset_busy_others got=%0b%0b exp=00", s2_busy, n16_busy); end
  endtask

  task automatic test_correct;
    apply(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL correct_busy_after_start got=%0b exp=1", busy); end
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b1, 3'(i), s_tab[i], c_tab[i]);
      if (i == 6) begin
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL correct_not_done_early got=%0b%0b exp=01", done, busy); end
      end
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL correct_done got=%0b exp=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL correct_busy_end got=%0b exp=0", busy); end
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL correct_pass got=%0b exp=1", pass); end
    checks++; if (err_count !== 4'd0) begin failures++; $display("FAIL correct_err got=%0d exp=0", err_count); end
    checks++; if (fail_seen !== 1'b0) begin failures++; $display("FAIL correct_fail_seen got=%0b exp=0", fail_seen); end
    apply(1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
    checks++; if (done !== 1'b1 || err_count !== 4'd0) begin failures++; $display("FAIL done_ignores_valid got done=%0b err=%0d exp done=1 err=0", done, err_count); end
  endtask

  task automatic test_sum_stuck;
    apply(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) apply(1'b0, 1'b1, 3'(i), 1'b0, c_tab[i]);
    checks++; if (err_count !== 4'd4) begin failures++; $display("FAIL stuck_err got=%0d exp=4", err_count); end
    checks++; if (fail_vec !== 3'b001) begin failures++; $display("FAIL stuck_fail_vec got=%0d exp=1", fail_vec); end
    checks++; if (fail_seen !== 1'b1) begin failures++; $display("FAIL stuck_fail_seen got=%0b exp=1", fail_seen); end
    checks++; if (pass !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL stuck_pass_done got=%0b%0b exp=01", pass, done); end
  endtask

  task automatic test_swap;
    logic [2:0] v;
    apply(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    checks++; if (err_count !== 4'd0) begin failures++; $display("FAIL restart_clears_err got=%0d exp=0", err_count); end
    checks++; if (fail_seen !== 1'b0 || fail_vec !== 3'd0) begin failures++; $display("FAIL restart_clears_fail got=%0b/%0d exp=0/0", fail_seen, fail_vec); end
    for (int i = 0; i < 8; i++) begin
      v = (i == 3) ? 3'd4 : (i == 4) ? 3'd3 : 3'(i);
      apply(1'b0, 1'b1, v, s_tab[v], c_tab[v]);
    end
    checks++; if (err_count !== 4'd2) begin failures++; $display("FAIL swap_err got=%0d exp=2", err_count); end
    checks++; if (fail_vec !== 3'b100) begin failures++; $display("FAIL swap_fail_vec got=%0d exp=4", fail_vec); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL swap_pass got=%0b exp=0", pass); end
  endtask

  task automatic test_saturate;
    apply(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) apply(1'b0, 1'b1, 3'(i), ~s_tab[i], ~c_tab[i]);
    checks++; if (s2_err_count !== 2'd3) begin failures++; $display("FAIL sat_err got=%0d exp=3", s2_err_count); end
    checks++; if (s2_fail_vec !== 3'b000 || s2_fail_seen !== 1'b1) begin failures++; $display("FAIL sat_fail got=%0d/%0b exp=0/1", s2_fail_vec, s2_fail_seen); end
    checks++; if (s2_pass !== 1'b0 || s2_done !== 1'b1) begin failures++; $display("FAIL sat_pass_done got=%0b%0b exp=01", s2_pass, s2_done); end
    checks++; if (err_count !== 4'd8) begin failures++; $display("FAIL invert_err_wide got=%0d exp=8", err_count); end
  endtask

  task automatic test_start_collision;
    apply(1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1 || err_count !== 4'd0) begin failures++; $display("FAIL collision_discard got busy=%0b err=%0d exp busy=1 err=0", busy, err_count); end
    for (int i = 0; i < 8; i++) apply(i == 3, 1'b1, 3'(i), s_tab[i], c_tab[i]);
    checks++; if (done !== 1'b1 || pass !== 1'b1) begin failures++; $display("FAIL collision_run_pass got done=%0b pass=%0b exp 1/1", done, pass); end
    checks++; if (err_count !== 4'd0) begin failures++; $display("FAIL collision_err got=%0d exp=0", err_count); end
  endtask

  task automatic test_gaps;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    apply(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 1'b1, 3'(i), s_tab[i % 8], c_tab[i % 8]);
      if (i == 14) begin
        checks++; if (n16_done !== 1'b0 || n16_busy !== 1'b1) begin failures++; $display("FAIL gaps_not_done_early got=%0b%0b exp=01", n16_done, n16_busy); end
      end
      if (i == 15) begin
        checks++; if (n16_done !== 1'b1) begin failures++; $display("FAIL gaps_done got=%0b exp=1", n16_done); end
      end
      apply(1'b0, 1'b0, 3'd7, 1'b0, 1'b0);
      apply(1'b0, 1'b0, 3'd7, 1'b0, 1'b0);
    end
    checks++; if (n16_pass !== 1'b1) begin failures++; $display("FAIL gaps_pass got=%0b exp=1", n16_pass); end
    checks++; if (n16_err_count !== 4'd0 || n16_fail_seen !== 1'b0) begin failures++; $display("FAIL gaps_err got=%0d/%0b exp=0/0", n16_err_count, n16_fail_seen); end
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL gaps_n8_pass got=%0b exp=1", pass); end
  endtask

  task automatic test_reset_midrun;
    apply(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 3'(i), (i == 0) ? s_tab[i] : ~s_tab[i], c_tab[i]);
    checks++; if (err_count !== 4'd4 || fail_vec !== 3'b001) begin failures++; $display("FAIL midrun_pre got err=%0d vec=%0d exp 4/1", err_count, fail_vec); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin failures++; $display("FAIL midrun_rst_state got=%0b%0b%0b exp=000", busy, done, pass); end
    checks++; if (err_count !== 4'd0 || fail_seen !== 1'b0 || fail_vec !== 3'd0) begin failures++; $display("FAIL midrun_rst_regs got=%0d/%0b/%0d exp=0/0/0", err_count, fail_seen, fail_vec); end
    @(negedge clk);
    rst = 1'b0;
    apply(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) apply(1'b0, 1'b1, 3'(i), s_tab[i], c_tab[i]);
    checks++; if (pass !== 1'b1 || err_count !== 4'd0) begin failures++; $display("FAIL midrun_rerun got pass=%0b err=%0d exp 1/0", pass, err_count); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_vec = 3'd0; in_s = 1'b0; in_c = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_correct;
    test_sum_stuck;
    test_swap;
    test_saturate;
    test_start_collision;
    test_gaps;
    test_reset_midrun;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
